load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: SPLIT_MISALIGNED, default 1, 1 = misaligned halfword/word accesses are split into byte accesses; 0 = misaligned requests return an error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  LSU can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I load/store funct3.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; the low bytes are used per size.
REQ-010 rsp_valid  output  1  one-cycle response pulse; not back-pressured.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  qualifies rsp_valid: illegal funct3 or rejected misalignment.
REQ-013 mem_we, mem_addr[31:0], mem_din[31:0], mem_funct3[2:0]  outputs  drive the data_memory port (writes on clk edge when mem_we=1).
REQ-014 mem_dout  input  32  data_memory combinational read data, already extended per mem_funct3.

Function
REQ-015 States: IDLE, ACCESS, SPLIT, RESP.
REQ-016 req_ready shall be 1 in IDLE and RESP and 0 in ACCESS and SPLIT.
REQ-017 A request is accepted when req_valid && req_ready; the request shall be captured at that edge.
REQ-018 Legal funct3 values: loads 000/001/010/100/101; stores 000/001/010.
REQ-019 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0; byte accesses are never misaligned.
REQ-020 Illegal funct3, or misaligned with SPLIT_MISALIGNED=0: go to RESP with rsp_err=1 and rsp_rdata=0; no memory access; latency 1 cycle from accept to rsp_valid.
REQ-021 Aligned legal request: ACCESS for 1 cycle, driving mem_addr=addr, mem_funct3=funct3, mem_din=wdata, and mem_we=req_we.
REQ-022 ACCESS, load: mem_dout is registered into rsp_rdata. Latency is 2 cycles from accept to rsp_valid.
REQ-023 Misaligned (SPLIT_MISALIGNED=1): SPLIT for n cycles (n=2 halfword, n=4 word). Byte k=0..n-1 uses mem_addr=addr+k (mod 2^32).
REQ-024 SPLIT store: mem_funct3=000, mem_din[7:0]=wdata byte k, mem_we=1.
REQ-025 SPLIT load: mem_funct3=100, mem_we=0, mem_dout[7:0] is captured into buffer byte k.
REQ-026 SPLIT load completion: LH shall sign-extend from bit 15; LHU shall zero-extend; LW is unchanged. rsp_valid latency is n+1 cycles from accept.
REQ-027 RESP: rsp_valid=1 for exactly one cycle. If a new request is accepted in RESP, the next state is chosen as from IDLE; otherwise the next state is IDLE.
REQ-028 mem_we shall be 0 in IDLE and RESP; other mem_* outputs hold their last value there.
REQ-029 Store response: rsp_rdata=0, rsp_err=0.

Reset
REQ-030 While rst_n=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_din=0, mem_funct3=010.
REQ-031 Reset mid-operation shall abort immediately with mem_we=0 asynchronously and no response. Bytes already written by a split store remain written.

Verification
REQ-032 SW 0xCAFEBABE @0x10, then LW @0x10 -> one mem_we cycle; second response rsp_rdata=0xCAFEBABE, rsp_valid 2 cycles after accept.
REQ-033 SW 0x11223344 @0x41 -> 4 mem_we cycles, addr 0x41..0x44, mem_funct3=000, din bytes 44,33,22,11; then LW @0x41 -> 0x11223344 at 5 cycles.
REQ-034 SB 0xEF @0x23, SB 0xBE @0x24, then LH @0x23 -> 0xFFFFBEEF; LHU @0x23 -> 0x0000BEEF.
REQ-035 Load funct3=011 -> rsp_err=1, rsp_rdata=0, mem_we never 1, rsp_valid 1 cycle after accept. Same with SPLIT_MISALIGNED=0 and LW @0x02.
REQ-036 rst_n low after 2 bytes of SW 0xAABBCCDD @0x51 -> outputs at reset values; LW @0x50 afterwards shows only 0x51=DD and 0x52=CC modified.
REQ-037 req_valid held high for back-to-back LW @0x10 -> second accept occurs in the RESP cycle; responses at cycles 2 and 4.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Purpose : RV32I load/store sequencer; optionally splits misaligned accesses
//           into byte accesses.
// Revision: 1.0
// ============================================================================
module load_store_unit #(
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_dout
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_SPLIT  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]  state, state_next;
    logic        op_we;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [1:0]  cnt, last, cnt_inc;
    logic [31:0] load_buf, buf_next, split_rdata;
    logic        accept, req_legal, req_misaligned, req_err, req_split;
    logic [1:0]  req_path;

    assign accept  = req_valid && req_ready;
    assign cnt_inc = cnt + 2'd1;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;
            default:                req_legal = 1'b0;
        endcase
    end

    assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_err   = !req_legal || (req_misaligned && (SPLIT_MISALIGNED == 0));
    assign req_split = req_misaligned && !req_err;
    assign req_path  = req_err ? ST_RESP : (req_split ? ST_SPLIT : ST_ACCESS);

    // Assemble the split-load word including the byte arriving this cycle.
    always_comb begin
        buf_next = load_buf;
        buf_next[{cnt, 3'b000} +: 8] = mem_dout[7:0];
        case (op_funct3)
            3'b001:  split_rdata = {{16{buf_next[15]}}, buf_next[15:0]};
            3'b101:  split_rdata = {16'h0000, buf_next[15:0]};
            default: split_rdata = buf_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_RESP: state_next = accept ? req_path : ST_IDLE;
            ST_ACCESS:        state_next = ST_RESP;
            ST_SPLIT:         state_next = (cnt == last) ? ST_RESP : ST_SPLIT;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE) || (state == ST_RESP);
        rsp_valid = (state == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we      <= 1'b0;
            op_funct3  <= 3'b000;
            op_addr    <= 32'h0;
            op_wdata   <= 32'h0;
            cnt        <= 2'd0;
            last       <= 2'd0;
            load_buf   <= 32'h0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_din    <= 32'h0;
            mem_funct3 <= 3'b010;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        op_we     <= req_we;
                        op_funct3 <= req_funct3;
                        op_addr   <= req_addr;
                        op_wdata  <= req_wdata;
                        cnt       <= 2'd0;
                        last      <= (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
                        load_buf  <= 32'h0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= req_err;
                        if (req_err) begin
                            mem_we <= 1'b0;
                        end else if (req_split) begin
                            mem_we     <= req_we;
                            mem_addr   <= req_addr;
                            mem_funct3 <= req_we ? 3'b000 : 3'b100;
                            mem_din    <= {24'h0, req_wdata[7:0]};
                        end else begin
                            mem_we     <= req_we;
                            mem_addr   <= req_addr;
                            mem_funct3 <= req_funct3;
                            mem_din    <= req_wdata;
                        end
                    end else begin
                        mem_we <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    mem_we    <= 1'b0;
                    rsp_rdata <= op_we ? 32'h0 : mem_dout;
                end
                ST_SPLIT: begin
                    load_buf <= buf_next;
                    if (cnt == last) begin
                        mem_we    <= 1'b0;
                        rsp_rdata <= op_we ? 32'h0 : split_rdata;
                    end else begin
                        cnt      <= cnt_inc;
                        mem_addr <= op_addr + {30'h0, cnt_inc};
                        mem_din  <= {24'h0, op_wdata[{cnt_inc, 3'b000} +: 8]};
                    end
                end
                default: mem_we <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Directed, table-driven bench for load_store_unit with a byte-addressed
// data memory model and a second instance built without split support.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
    logic [2:0]  mem_funct3;

    logic        ns_req_valid = 1'b0, ns_req_we = 1'b0;
    logic [2:0]  ns_req_funct3 = 3'b010;
    logic [31:0] ns_req_addr = 32'h0;
    logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_mem_we;
    logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_din;
    logic [2:0]  ns_mem_funct3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_MISALIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_funct3(mem_funct3), .mem_dout(mem_dout)
    );

    load_store_unit #(.SPLIT_MISALIGNED(0)) u_nosplit (
        .clk(clk), .rst_n(rst_n),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we),
        .req_funct3(ns_req_funct3), .req_addr(ns_req_addr), .req_wdata(32'h0),
        .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err),
        .mem_we(ns_mem_we), .mem_addr(ns_mem_addr), .mem_din(ns_mem_din),
        .mem_funct3(ns_mem_funct3), .mem_dout(32'h0)
    );

    // Data memory model: little-endian bytes, synchronous write, comb read.
    logic [7:0] mem [0:255];
    logic       mem_init = 1'b1;
    logic [7:0] a0, a1, a2, a3;
    assign a0 = mem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[a0] <= mem_din[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[a1] <= mem_din[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[a2] <= mem_din[23:16];
                mem[a3] <= mem_din[31:24];
            end
        end
    end

    always_comb begin
        case (mem_funct3)
            3'b000:  mem_dout = {{24{mem[a0][7]}}, mem[a0]};
            3'b001:  mem_dout = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b100:  mem_dout = {24'h0, mem[a0]};
            3'b101:  mem_dout = {16'h0, mem[a1], mem[a0]};
            default: mem_dout = {mem[a3], mem[a2], mem[a1], mem[a0]};
        endcase
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          wes;
    } vec_t;

    vec_t vecs [16];

    logic [31:0] log_addr [8];
    logic [31:0] log_din  [8];
    logic [2:0]  log_f3   [8];
    int          log_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic err,
                          output logic [31:0] rdata, output int lat, output int wes);
        lat = 0; wes = 0; err = 1'b0; rdata = 32'h0; log_n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) begin
                if (log_n < 8) begin
                    log_addr[log_n] = mem_addr;
                    log_din[log_n]  = mem_din;
                    log_f3[log_n]   = mem_funct3;
                end
                log_n++;
                wes++;
            end
            if (rsp_valid) begin
                lat = c; err = rsp_err; rdata = rsp_rdata;
                break;
            end
        end
    endtask

    logic        r_err;
    logic [31:0] r_rdata;
    int          r_lat, r_wes;
    logic [5:1]  pattern;
    int          stray;
    logic [31:0] exp_b;

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hCAFEBABE, 1'b0, 32'h0,        2, 1};
        vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hCAFEBABE, 2, 0};
        vecs[2]  = '{1'b1, 3'b010, 32'h41, 32'h11223344, 1'b0, 32'h0,        5, 4};
        vecs[3]  = '{1'b0, 3'b010, 32'h41, 32'h0,        1'b0, 32'h11223344, 5, 0};
        vecs[4]  = '{1'b1, 3'b000, 32'h23, 32'h000000EF, 1'b0, 32'h0,        2, 1};
        vecs[5]  = '{1'b1, 3'b000, 32'h24, 32'h000000BE, 1'b0, 32'h0,        2, 1};
        vecs[6]  = '{1'b0, 3'b001, 32'h23, 32'h0,        1'b0, 32'hFFFFBEEF, 3, 0};
        vecs[7]  = '{1'b0, 3'b101, 32'h23, 32'h0,        1'b0, 32'h0000BEEF, 3, 0};
        vecs[8]  = '{1'b0, 3'b011, 32'h00, 32'h0,        1'b1, 32'h0,        1, 0};
        vecs[9]  = '{1'b1, 3'b100, 32'h00, 32'h12345678, 1'b1, 32'h0,        1, 0};
        vecs[10] = '{1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFFCA, 2, 0};
        vecs[11] = '{1'b0, 3'b100, 32'h12, 32'h0,        1'b0, 32'h000000FE, 2, 0};
        vecs[12] = '{1'b0, 3'b001, 32'h10, 32'h0,        1'b0, 32'hFFFFBABE, 2, 0};
        vecs[13] = '{1'b1, 3'b001, 32'h31, 32'h00001234, 1'b0, 32'h0,        3, 2};
        vecs[14] = '{1'b0, 3'b101, 32'h31, 32'h0,        1'b0, 32'h00001234, 3, 0};
        vecs[15] = '{1'b0, 3'b010, 32'h42, 32'h0,        1'b0, 32'h00112233, 5, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready",  {31'h0, req_ready},  32'h1);
        chk("reset_rsp_valid",  {31'h0, rsp_valid},  32'h0);
        chk("reset_rsp_err",    {31'h0, rsp_err},    32'h0);
        chk("reset_rsp_rdata",  rsp_rdata,           32'h0);
        chk("reset_mem_we",     {31'h0, mem_we},     32'h0);
        chk("reset_mem_addr",   mem_addr,            32'h0);
        chk("reset_mem_din",    mem_din,             32'h0);
        chk("reset_mem_funct3", {29'h0, mem_funct3}, 32'h2);
        @(negedge clk);
        mem_init = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, r_err, r_rdata, r_lat, r_wes);
            chk($sformatf("v%0d_err", i),   {31'h0, r_err},    {31'h0, vecs[i].err});
            chk($sformatf("v%0d_rdata", i), r_rdata,           vecs[i].rdata);
            chk($sformatf("v%0d_lat", i),   r_lat,             vecs[i].lat);
            chk($sformatf("v%0d_wes", i),   r_wes,             vecs[i].wes);
        end

        // Split store byte sequence
        do_req(1'b1, 3'b010, 32'h61, 32'h11223344, r_err, r_rdata, r_lat, r_wes);
        chk("split_sw_count", log_n, 4);
        for (int k = 0; k < 4; k++) begin
            exp_b = 32'h11223344 >> (8 * k);
            chk($sformatf("split_sw_addr%0d", k), log_addr[k], 32'h61 + k);
            chk($sformatf("split_sw_din%0d", k),  {24'h0, log_din[k][7:0]}, {24'h0, exp_b[7:0]});
            chk($sformatf("split_sw_f3_%0d", k),  {29'h0, log_f3[k]}, 32'h0);
        end

        // Reset in the middle of a split store, after two bytes
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h51; req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we",     {31'h0, mem_we},     32'h0);
        chk("midrst_rsp_valid",  {31'h0, rsp_valid},  32'h0);
        chk("midrst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("midrst_mem_addr",   mem_addr,            32'h0);
        chk("midrst_mem_din",    mem_din,             32'h0);
        chk("midrst_mem_funct3", {29'h0, mem_funct3}, 32'h2);
        stray = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid || mem_we) stray++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid || mem_we) stray++;
        end
        chk("midrst_no_activity", stray, 0);
        do_req(1'b0, 3'b010, 32'h50, 32'h0, r_err, r_rdata, r_lat, r_wes);
        chk("midrst_lw_0x50", r_rdata, 32'h00CCDD00);

        // Back-to-back loads with req_valid held high
        pattern = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            pattern[c] = rsp_valid;
            if (rsp_valid) chk($sformatf("b2b_rdata_c%0d", c), rsp_rdata, 32'hCAFEBABE);
            if (c == 2) begin
                chk("b2b_ready_in_resp", {31'h0, req_ready}, 32'h1);
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("b2b_rsp_pattern", {27'h0, pattern}, 32'h0000000A);

        // Instance without split support: misaligned word errors out
        @(negedge clk);
        ns_req_valid = 1'b1; ns_req_we = 1'b0; ns_req_funct3 = 3'b010; ns_req_addr = 32'h02;
        @(posedge clk);
        #1 ns_req_valid = 1'b0;
        @(negedge clk);
        chk("ns_mis_valid", {31'h0, ns_rsp_valid}, 32'h1);
        chk("ns_mis_err",   {31'h0, ns_rsp_err},   32'h1);
        chk("ns_mis_rdata", ns_rsp_rdata,          32'h0);
        chk("ns_mis_we",    {31'h0, ns_mem_we},    32'h0);
        @(negedge clk);
        ns_req_valid = 1'b1; ns_req_addr = 32'h04;
        @(posedge clk);
        #1 ns_req_valid = 1'b0;
        @(negedge clk);
        chk("ns_al_c1_valid", {31'h0, ns_rsp_valid}, 32'h0);
        chk("ns_al_c1_addr",  ns_mem_addr,           32'h04);
        @(negedge clk);
        chk("ns_al_c2_valid", {31'h0, ns_rsp_valid}, 32'h1);
        chk("ns_al_c2_err",   {31'h0, ns_rsp_err},   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
